// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone arbiter in front of the IRAM/DRAM RAM port: round-robin on contention,
// grant held until ack, with a watchdog that turns a silent slave into a bus error.
module wb_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  wb_clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  input  logic                  m0_we_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_cyc_i,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  input  logic                  m1_we_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_cyc_i,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_wdata_o,
  output logic                  s_we_o,
  output logic                  s_stb_o,
  output logic                  s_cyc_o,
  input  logic [DATA_WIDTH-1:0] s_rdata_i,
  input  logic                  s_ack_i,
  output logic [1:0]            grant_o
);

  // Keep the counter at least one bit wide so a disabled watchdog still elaborates.
  localparam int unsigned   CntW       = (CNT_WIDTH > 0) ? CNT_WIDTH : 1;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYCLES);
  localparam bit            WdEnable   = (TIMEOUT_CYCLES != 0);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_owner_q, last_owner_d;
  logic [CntW-1:0] wd_cnt_q, wd_cnt_d;

  logic req0, req1, busy, own_cyc, own_stb, timeout;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign busy    = (state_q == StBusy);
  assign own_cyc = owner_q ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner_q ? m1_stb_i : m0_stb_i;
  // An abort (owner dropped cyc) takes priority over the error; an ack beats both.
  assign timeout = WdEnable && busy && own_cyc && !s_ack_i && (wd_cnt_q == TimeoutVal);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wd_cnt_d     = wd_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          owner_d  = (req0 && req1) ? ~last_owner_q : req1;
          wd_cnt_d = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (s_ack_i || !own_cyc || timeout) begin
          last_owner_d = owner_q;
          state_d      = StIdle;
        end else if (WdEnable) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  always_comb begin
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_we_o     = 1'b0;
    s_stb_o    = 1'b0;
    s_cyc_o    = 1'b0;
    grant_o    = 2'b00;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_rdata_o = '0;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_rdata_o = '0;
    if (busy) begin
      grant_o   = owner_q ? 2'b10 : 2'b01;
      s_addr_o  = owner_q ? m1_addr_i : m0_addr_i;
      s_wdata_o = owner_q ? m1_wdata_i : m0_wdata_i;
      s_we_o    = owner_q ? m1_we_i : m0_we_i;
      s_cyc_o   = own_cyc & own_stb & ~timeout;
      s_stb_o   = own_cyc & own_stb & ~timeout;
      if (owner_q) begin
        m1_ack_o   = s_ack_i;
        m1_rdata_o = s_rdata_i;
        m1_err_o   = timeout;
      end else begin
        m0_ack_o   = s_ack_i;
        m0_rdata_o = s_rdata_i;
        m0_err_o   = timeout;
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Scoreboard bench for wb_ram_arbiter: stimulus queues expected grants/responses, a negedge
// monitor pops and compares them whenever the DUT grants or answers.
module tb_wb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m_addr[2];
  logic [31:0] m_wdata[2];
  logic        m_we[2];
  logic        m_stb[2];
  logic        m_cyc[2];
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_we, s_stb, s_cyc, s_ack;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  wb_ram_arbiter #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .wb_clk_i  (clk),
    .rst_ni    (rst_n),
    .m0_addr_i (m_addr[0]),
    .m0_wdata_i(m_wdata[0]),
    .m0_we_i   (m_we[0]),
    .m0_stb_i  (m_stb[0]),
    .m0_cyc_i  (m_cyc[0]),
    .m0_rdata_o(m0_rdata),
    .m0_ack_o  (m0_ack),
    .m0_err_o  (m0_err),
    .m1_addr_i (m_addr[1]),
    .m1_wdata_i(m_wdata[1]),
    .m1_we_i   (m_we[1]),
    .m1_stb_i  (m_stb[1]),
    .m1_cyc_i  (m_cyc[1]),
    .m1_rdata_o(m1_rdata),
    .m1_ack_o  (m1_ack),
    .m1_err_o  (m1_err),
    .s_addr_o  (s_addr),
    .s_wdata_o (s_wdata),
    .s_we_o    (s_we),
    .s_stb_o   (s_stb),
    .s_cyc_o   (s_cyc),
    .s_rdata_i (s_rdata),
    .s_ack_i   (s_ack),
    .grant_o   (grant)
  );

  typedef struct {
    logic [1:0]  grant;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic [3:0]  flags;  // {m1_err, m0_err, m1_ack, m0_ack}
    logic [31:0] rdata;
    int          cyc;    // BUSY cycle in which the response appears
  } rsp_t;

  txn_t txn_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_txn(input logic [1:0] g, input logic [31:0] a, input logic we,
                          input logic [31:0] wd);
    txn_t t;
    t.grant = g; t.addr = a; t.we = we; t.wdata = wd;
    txn_q.push_back(t);
  endtask

  task automatic push_rsp(input logic [3:0] f, input logic [31:0] rd, input int cyc);
    rsp_t r;
    r.flags = f; r.rdata = rd; r.cyc = cyc;
    rsp_q.push_back(r);
  endtask

  // RAM model: acks in BUSY cycle ack_delay (0 = never), returning rd_val with the ack.
  int          ack_delay = 0;
  int          scnt = 0;
  logic [31:0] rd_val = '0;
  assign s_rdata = s_ack ? rd_val : 32'h0;

  always @(posedge clk) begin
    #1;
    if (grant == 2'b00) begin
      scnt  = 0;
      s_ack = 1'b0;
    end else begin
      scnt++;
      s_ack = (ack_delay != 0) && (scnt == ack_delay);
    end
  end

  logic [1:0] prev_grant;
  int         busy_cnt;
  logic       prev_done;
  logic [3:0] flags;
  txn_t       mt;
  rsp_t       mr;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_grant = 2'b00;
      busy_cnt   = 0;
      prev_done  = 1'b0;
    end else begin
      if (prev_done) chk("idle_after_done", grant, 2'b00);
      prev_done = 1'b0;
      if (grant != 2'b00) begin
        if (prev_grant == 2'b00) begin
          busy_cnt = 1;
          if (txn_q.size() == 0) chk("unexpected_grant", grant, 2'b00);
          else begin
            mt = txn_q.pop_front();
            chk("grant", grant, mt.grant);
            chk("s_addr", s_addr, mt.addr);
            chk("s_we", s_we, mt.we);
            if (mt.we) chk("s_wdata", s_wdata, mt.wdata);
            chk("s_cyc_stb", {s_cyc, s_stb}, 2'b11);
          end
        end else begin
          busy_cnt++;
        end
      end
      flags = {m1_err, m0_err, m1_ack, m0_ack};
      if (flags != 4'b0000) begin
        prev_done = 1'b1;
        if (rsp_q.size() == 0) chk("unexpected_rsp", flags, 4'b0000);
        else begin
          mr = rsp_q.pop_front();
          chk("rsp_flags", flags, mr.flags);
          chk("rsp_cycle", busy_cnt, mr.cyc);
          chk("m0_rdata", m0_rdata, mr.flags[0] ? mr.rdata : 32'h0);
          chk("m1_rdata", m1_rdata, mr.flags[1] ? mr.rdata : 32'h0);
          if (mr.flags[3:2] != 2'b00) chk("stb_in_err", {s_cyc, s_stb}, 2'b00);
        end
      end
      prev_grant = grant;
    end
  end

  task automatic m_start(input int i, input logic [31:0] a, input logic we,
                         input logic [31:0] wd);
    @(posedge clk);
    #2;
    m_addr[i] = a; m_we[i] = we; m_wdata[i] = wd; m_cyc[i] = 1'b1; m_stb[i] = 1'b1;
  endtask

  task automatic m_wait(input int i);
    logic done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      done = (i == 1) ? (m1_ack | m1_err) : (m0_ack | m0_err);
    end
    chk($sformatf("m%0d_response_seen", i), done, 1'b1);
  endtask

  task automatic m_idle(input int i);
    @(posedge clk);
    #2;
    m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_wdata[i] = '0; m_we[i] = 1'b0; m_stb[i] = 1'b0; m_cyc[i] = 1'b0;
    end
    s_ack = 1'b0;
    rst_n = 1'b0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = 32'hFFFF_0000;
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc_stb", {s_cyc, s_stb}, 2'b00);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_m0_ack_err", {m0_ack, m0_err}, 2'b00);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; m_addr[0] = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Continuous contention: m0, m1, m0, m1 with an idle cycle between grants.
    rd_val = 32'hCAFE_0001; ack_delay = 2;
    push_txn(2'b01, 32'h100, 1'b0, 32'h0); push_rsp(4'b0001, 32'hCAFE_0001, 2);
    push_txn(2'b10, 32'h200, 1'b0, 32'h0); push_rsp(4'b0010, 32'hCAFE_0001, 2);
    push_txn(2'b01, 32'h104, 1'b0, 32'h0); push_rsp(4'b0001, 32'hCAFE_0001, 2);
    push_txn(2'b10, 32'h204, 1'b0, 32'h0); push_rsp(4'b0010, 32'hCAFE_0001, 2);
    fork
      begin
        m_start(0, 32'h100, 1'b0, 32'h0); m_wait(0);
        m_start(0, 32'h104, 1'b0, 32'h0); m_wait(0); m_idle(0);
      end
      begin
        m_start(1, 32'h200, 1'b0, 32'h0); m_wait(1);
        m_start(1, 32'h204, 1'b0, 32'h0); m_wait(1); m_idle(1);
      end
    join

    // m0 alone: one-cycle arbitration latency, ack in BUSY cycle 3.
    rd_val = 32'hDEAD_BEEF; ack_delay = 3;
    push_txn(2'b01, 32'h0010_0004, 1'b0, 32'h0); push_rsp(4'b0001, 32'hDEAD_BEEF, 3);
    m_start(0, 32'h0010_0004, 1'b0, 32'h0);
    @(negedge clk); chk("latency_idle_stb", s_stb, 1'b0);
    @(negedge clk); chk("latency_busy_stb", s_stb, 1'b1);
    m_wait(0); m_idle(0);

    // m1 write.
    rd_val = 32'h0; ack_delay = 2;
    push_txn(2'b10, 32'h0000_0100, 1'b1, 32'h1234_5678); push_rsp(4'b0010, 32'h0, 2);
    m_start(1, 32'h0000_0100, 1'b1, 32'h1234_5678); m_wait(1); m_idle(1);

    // Watchdog: m0 gets err in BUSY cycle 17, then pending m1 is served.
    rd_val = 32'h55AA_55AA; ack_delay = 0;
    push_txn(2'b01, 32'h40, 1'b0, 32'h0); push_rsp(4'b0100, 32'h0, 17);
    push_txn(2'b10, 32'h80, 1'b0, 32'h0); push_rsp(4'b0010, 32'h55AA_55AA, 2);
    fork
      begin m_start(0, 32'h40, 1'b0, 32'h0); m_wait(0); ack_delay = 2; m_idle(0); end
      begin m_start(1, 32'h80, 1'b0, 32'h0); m_wait(1); m_idle(1); end
    join

    // Abort: m0 drops cyc in BUSY cycle 2, pending m1 served afterwards.
    rd_val = 32'h0BAD_F00D; ack_delay = 0;
    push_txn(2'b01, 32'h300, 1'b0, 32'h0);
    push_txn(2'b10, 32'h400, 1'b0, 32'h0); push_rsp(4'b0010, 32'h0BAD_F00D, 3);
    fork
      begin
        m_start(0, 32'h300, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk); chk("abort_grant_b1", grant, 2'b01);
        @(posedge clk); #2 m_cyc[0] = 1'b0;
        @(negedge clk); chk("abort_stb_b2", {s_cyc, s_stb}, 2'b00);
        ack_delay = 3;
        @(negedge clk); chk("abort_idle", grant, 2'b00);
        m_stb[0] = 1'b0;
      end
      begin m_start(1, 32'h400, 1'b0, 32'h0); m_wait(1); m_idle(1); end
    join

    // m0 completes (last_owner=m0), then a second m0 transaction is cut by reset.
    rd_val = 32'h1111_2222; ack_delay = 1;
    push_txn(2'b01, 32'h500, 1'b0, 32'h0); push_rsp(4'b0001, 32'h1111_2222, 1);
    push_txn(2'b01, 32'h510, 1'b0, 32'h0);
    m_start(0, 32'h500, 1'b0, 32'h0); m_wait(0);
    ack_delay = 0;
    m_start(0, 32'h510, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_s_cyc_stb", {s_cyc, s_stb}, 2'b00);
    chk("midrst_m0_ack_err", {m0_ack, m0_err}, 2'b00);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;

    // After reset the tie goes to m0.
    rd_val = 32'h600D_0000; ack_delay = 1;
    push_txn(2'b01, 32'h600, 1'b0, 32'h0); push_rsp(4'b0001, 32'h600D_0000, 1);
    push_txn(2'b10, 32'h700, 1'b0, 32'h0); push_rsp(4'b0010, 32'h600D_0000, 1);
    fork
      begin m_start(0, 32'h600, 1'b0, 32'h0); m_wait(0); m_idle(0); end
      begin m_start(1, 32'h700, 1'b0, 32'h0); m_wait(1); m_idle(1); end
    join

    repeat (5) @(negedge clk);
    chk("txn_q_drained", txn_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
Two-master Wishbone arbiter that shares the single slave port of the IRAM/DRAM wishbone RAM interface between the core data port (m0) and the debug/program loader (m1). It grants one transaction at a time, round-robin on contention, and holds the grant until the RAM acknowledges. A watchdog returns a bus error if the slave never responds. It sits between the masters and the RAM interface in the wb_clk_i domain.

Parameters:
ADDR_WIDTH, 32, address width on all ports
DATA_WIDTH, 32, data width on all ports
TIMEOUT_CYCLES, 16, BUSY cycles without ack before error; 0 disables the watchdog
CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), watchdog counter width

Ports:
wb_clk_i  input  1  single clock for all logic
rst_ni  input  1  reset, asynchronous, active-low
m0_addr_i / m1_addr_i  input  ADDR_WIDTH  master address
m0_wdata_i / m1_wdata_i  input  DATA_WIDTH  master write data
m0_we_i / m1_we_i  input  1  master write enable (1 = write, 0 = read)
m0_stb_i / m1_stb_i  input  1  master strobe
m0_cyc_i / m1_cyc_i  input  1  master cycle
m0_rdata_o / m1_rdata_o  output  DATA_WIDTH  read data, valid with ack
m0_ack_o / m1_ack_o  output  1  acknowledge to master
m0_err_o / m1_err_o  output  1  timeout error to master, one-cycle pulse
s_addr_o  output  ADDR_WIDTH  address to RAM interface
s_wdata_o  output  DATA_WIDTH  write data to RAM interface
s_we_o  output  1  write enable to RAM interface
s_stb_o  output  1  strobe to RAM interface
s_cyc_o  output  1  cycle to RAM interface
s_rdata_i  input  DATA_WIDTH  read data from RAM interface
s_ack_i  input  1  acknowledge from RAM interface
grant_o  output  2  one-hot current owner {m1,m0}; 0 when IDLE

Behaviour:
- Request: req_n = mN_cyc_i & mN_stb_i.
- Registered state: state {IDLE, BUSY}, owner (1 bit), last_owner (1 bit), wd_cnt (CNT_WIDTH).
- Reset: state=IDLE, owner=0, last_owner=1 (m0 wins the first tie), wd_cnt=0. All outputs 0: s_*_o, mN_ack_o, mN_err_o, mN_rdata_o, grant_o.
- IDLE:
  - Only one req: grant that master.
  - Both req: grant the master that is not last_owner.
  - On grant: owner is registered, wd_cnt=0, state moves to BUSY at the next edge.
  - Downstream stays idle in this state.
  - Arbitration latency: exactly 1 cycle from req to s_stb_o.
- BUSY:
  - s_addr/wdata/we_o are the owner's inputs, muxed combinationally.
  - s_cyc_o = s_stb_o = owner's cyc & stb, forced to 0 in the error cycle.
  - grant_o is one-hot for the owner.
  - Owner's mN_ack_o = s_ack_i and mN_rdata_o = s_rdata_i, both combinational. The non-owner sees ack=0 and rdata=0.
  - s_ack_i=1: last_owner<=owner, state->IDLE. The next grant arrives one cycle later; there is one mandatory idle cycle between transactions.
  - Owner drops cyc before ack (abort): state->IDLE, no ack/err, last_owner<=owner.
  - Watchdog (TIMEOUT_CYCLES>0):
    - wd_cnt increments on every BUSY cycle without ack.
    - When wd_cnt==TIMEOUT_CYCLES and no ack: owner's mN_err_o=1 for that cycle, s_stb/cyc_o=0, last_owner<=owner, state->IDLE.
    - Ack in the same cycle wins: ack is given, no err.
  - Non-owner requests are held (no ack) until re-arbitrated in IDLE.
- Owner's address/data are not latched; masters hold them stable per Wishbone until ack.
- Reset asserted mid-transaction: immediate return to the reset values; the pending transaction is dropped with no ack.
- At most one of ack/err is asserted per transaction, to the owner only.

Test Plan:
- m0 only, read addr 0x0010_0004: s_stb_o rises 1 cycle after req. RAM acks after 3 cycles with 0xDEADBEEF -> m0_ack_o=1 same cycle, m0_rdata_o=0xDEADBEEF, m1_ack_o=0, grant_o=2'b01.
- Both masters request continuously, 4 transactions -> grant order m0,m1,m0,m1, with one IDLE cycle between grants.
- m1 write to 0x0000_0100 with data 0x1234_5678 -> s_we_o=1, s_addr_o=0x0000_0100, s_wdata_o=0x1234_5678; m1_ack_o mirrors s_ack_i.
- TIMEOUT_CYCLES=16, s_ack_i held 0 -> m0_err_o pulses once in BUSY cycle 17 with s_stb_o=0; the pending m1 request is granted on the following arbitration.
- m0 drops cyc in BUSY cycle 2 -> next cycle IDLE, no ack/err; a pending m1 request is granted after that.
- rst_ni pulled low mid-BUSY -> grant_o=0, s_stb_o=0, no ack. After release, a simultaneous request from both masters -> m0 granted.
